// File: rtl/circuit2_seq_ctrl.sv
// circuit2_seq_ctrl: multi-cycle circuit_2 dataflow sharing one add/sub unit and one comparator
module circuit2_seq_ctrl #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z,
  output logic [2:0]           state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ADD1 = 3'd1, ADD2 = 3'd2, SUB = 3'd3, OUT = 3'd4} state_t;
  state_t st;
  logic [DATAWIDTH-1:0] a_r, b_r, c_r, d, e, f, op_b, alu, g, h;
  logic lt, eq;
  // shared add/sub unit: second operand is c only in ADD2, subtract only in SUB
  always_comb begin
    op_b = (st == ADD2) ? c_r : b_r;
    alu  = (st == SUB) ? a_r - op_b : a_r + op_b;
    g    = lt ? e : d;
    h    = eq ? f : g;
  end
  assign busy  = st != IDLE;
  assign state = st;
  // sequencer: one shared-unit operation per cycle, results registered in OUT
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st   <= IDLE;
      done <= 1'b0;
      x    <= '0;
      z    <= '0;
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      d    <= '0;
      e    <= '0;
      f    <= '0;
      lt   <= 1'b0;
      eq   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          c_r <= c;
          st  <= ADD1;
        end
        ADD1: begin
          d  <= alu;
          st <= ADD2;
        end
        ADD2: begin
          e  <= alu;
          st <= SUB;
        end
        SUB: begin
          f  <= alu;
          lt <= d < e;
          eq <= d == e;
          st <= OUT;
        end
        OUT: begin
          x    <= g << lt;
          z    <= h >> eq;
          done <= 1'b1;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_circuit2_seq_ctrl.sv
// tb_circuit2_seq_ctrl: directed and random checks of circuit2_seq_ctrl against an arithmetic model
module tb_circuit2_seq_ctrl;
  logic Clk, Rst, start, busy, done;
  logic [31:0] a, b, c, x, z;
  logic [2:0] state;
  int n_checks = 0;
  int n_fails = 0;

  circuit2_seq_ctrl #(.DATAWIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .x(x), .z(z), .state(state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // reference: the dataflow computed straight from its definition
  function automatic logic [63:0] model(input logic [31:0] ia, ib, ic);
    logic [31:0] dm, em, fm, gm, hm, xm, zm;
    dm = ia + ib;
    em = ia + ic;
    fm = ia - ib;
    gm = (dm < em) ? em : dm;
    hm = (dm == em) ? fm : gm;
    xm = (dm < em) ? gm * 2 : gm;
    zm = (dm == em) ? hm / 2 : hm;
    return {xm, zm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] ia, ib, ic, input bit disturb);
    logic [63:0] r;
    r = model(ia, ib, ic);
    @(negedge Clk);
    a = ia; b = ib; c = ic; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check("accept_state", 32'(state), 32'd1);
    check("accept_busy", 32'(busy), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      if (disturb) begin
        a = $urandom; b = $urandom; c = $urandom; start = (i != 4);
      end
      @(negedge Clk);
      check("run_state", 32'(state), 32'(i));
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    @(negedge Clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_state", 32'(state), 32'd0);
    check("x", x, r[63:32]);
    check("z", z, r[31:0]);
    @(negedge Clk);
    check("done_single", 32'(done), 32'd0);
    check("idle_after", 32'(state), 32'd0);
    check("x_hold", x, r[63:32]);
    check("z_hold", z, r[31:0]);
  endtask

  initial begin
    logic [31:0] ca[4], cb[4], cc[4];
    logic [63:0] r;
    logic [31:0] ra, rb, rc;
    Rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_x", x, 32'd0);
    check("rst_z", z, 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("idle_state", 32'(state), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_x", x, 32'd0);
      check("idle_z", z, 32'd0);
    end
    run_op(32'd5, 32'd3, 32'd10, 1'b0);
    check("basic_x", x, 32'd30);
    check("basic_z", z, 32'd15);
    run_op(32'd4, 32'd6, 32'd6, 1'b0);
    check("eq_x", x, 32'd10);
    check("eq_z", z, 32'h7FFF_FFFF);
    run_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    check("wrap_x", x, 32'hFFFF_FFFE);
    check("wrap_z", z, 32'hFFFF_FFFF);
    run_op(32'd1, 32'd9, 32'd2, 1'b0);
    check("gt_x", x, 32'd10);
    check("gt_z", z, 32'd10);
    run_op(32'd7, 32'd2, 32'd1, 1'b1);
    check("busy_ignore_x", x, 32'd9);
    for (int k = 0; k < 4; k++) begin
      ca[k] = $urandom; cb[k] = $urandom; cc[k] = (k == 1) ? cb[k] : $urandom;
    end
    @(negedge Clk);
    a = ca[0]; b = cb[0]; c = cc[0]; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r = model(ca[k], cb[k], cc[k]);
      @(negedge Clk);
      check("cont_accept", 32'(state), 32'd1);
      a = $urandom; b = $urandom; c = $urandom;
      repeat (3) begin
        @(negedge Clk);
        check("cont_nodone", 32'(done), 32'd0);
      end
      @(negedge Clk);
      check("cont_done", 32'(done), 32'd1);
      check("cont_x", x, r[63:32]);
      check("cont_z", z, r[31:0]);
      if (k < 3) begin
        a = ca[k+1]; b = cb[k+1]; c = cc[k+1];
      end else start = 1'b0;
    end
    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = (k % 4 == 0) ? $urandom_range(15) : $urandom;
      rc = (k % 3 == 0) ? rb : $urandom;
      run_op(ra, rb, rc, k[0]);
    end
    @(negedge Clk);
    a = 32'd100; b = 32'd50; c = 32'd20; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("pre_rst_sub", 32'(state), 32'd3);
    Rst = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_x", x, 32'd0);
    check("abort_z", z, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("abort_nodone", 32'(done), 32'd0);
      check("abort_idle", 32'(state), 32'd0);
    end
    run_op(32'd5, 32'd3, 32'd10, 1'b0);
    check("after_abort_x", x, 32'd30);
    check("after_abort_z", z, 32'd15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
